symbol_serializer: RTL and testbench

SYMBOL_SERIALIZER -- requirements
Module: symbol_serializer

---
 rtl/symbol_serializer_if.sv | 15 +
 rtl/symbol_serializer.sv | 53 +++++
 tb/tb_symbol_serializer.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/symbol_serializer_if.sv
// symbol_serializer_if: word-in / QPSK-symbol-out handshake bundle
interface symbol_serializer_if;
    logic [7:0] in0, in1, in2, in3;
    logic       in_valid, in_ready;
    logic [1:0] sym;
    logic       sym_valid, sym_ready, sym_last;
    modport slave (
        input  in0, in1, in2, in3, in_valid, sym_ready,
        output in_ready, sym, sym_valid, sym_last
    );
    modport master (
        output in0, in1, in2, in3, in_valid, sym_ready,
        input  in_ready, sym, sym_valid, sym_last
    );
endinterface

// File: rtl/symbol_serializer.sv
// symbol_serializer: splits 32-bit words into 16 QPSK symbols, LSB pair of in0 first
module symbol_serializer #(
    parameter logic [1:0] IDLE_SYM = 2'b00
) (
    input logic clk,
    input logic rst,
    symbol_serializer_if.slave bus
);
    typedef enum logic {IDLE, SHIFT} state_t;
    state_t      state;
    logic [31:0] active, pend, word;
    logic [3:0]  k;
    logic        pend_full, word_xfer, sym_xfer;
    assign word      = {bus.in3, bus.in2, bus.in1, bus.in0};
    assign word_xfer = bus.in_valid && !pend_full;
    assign sym_xfer  = (state == SHIFT) && bus.sym_ready;
    assign bus.in_ready  = !pend_full;
    assign bus.sym_valid = state == SHIFT;
    assign bus.sym       = (state == SHIFT) ? active[1:0] : IDLE_SYM;
    assign bus.sym_last  = (state == SHIFT) && (k == 4'd15);
    // active shifts right so the current symbol is always its low pair
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            k         <= 4'd0;
            pend_full <= 1'b0;
            active    <= '0;
            pend      <= '0;
        end else if (state == IDLE) begin
            if (word_xfer) begin
                active <= word;
                k      <= 4'd0;
                state  <= SHIFT;
            end
        end else if (sym_xfer && k == 4'd15) begin
            k <= 4'd0;
            if (pend_full) begin
                active    <= pend;
                pend_full <= 1'b0;
            end else if (word_xfer) active <= word;
            else state <= IDLE;
        end else begin
            if (sym_xfer) begin
                active <= {2'b00, active[31:2]};
                k      <= k + 4'd1;
            end
            if (word_xfer) begin
                pend      <= word;
                pend_full <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_symbol_serializer.sv
// tb_symbol_serializer: directed + random stimulus against a symbol-queue reference model
module tb_symbol_serializer;
    localparam logic [1:0] IDLE = 2'b10;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    symbol_serializer_if bus();
    symbol_serializer #(.IDLE_SYM(IDLE)) dut (.clk(clk), .rst(rst), .bus(bus));
    logic [2:0] q[$];
    logic [1:0] seen[$];
    int checks = 0;
    int passes = 0;
    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask
    function automatic bit ready_exp();
        return ((q.size() + 15) / 16) < 2;
    endfunction
    task automatic push_word(input logic [7:0] b0, b1, b2, b3);
        logic [7:0] b[4];
        b = '{b0, b1, b2, b3};
        for (int i = 0; i < 16; i++) q.push_back({1'(i == 15), b[i / 4][2 * (i % 4) +: 2]});
    endtask
    task automatic cycle(input bit chk, output bit acc);
        bit v;
        v = q.size() != 0;
        if (chk) begin
            check("sym_valid", 8'(bus.sym_valid), 8'(v));
            check("sym", 8'(bus.sym), 8'(v ? q[0][1:0] : IDLE));
            check("sym_last", 8'(bus.sym_last), 8'(v && q[0][2]));
            check("in_ready", 8'(bus.in_ready), 8'(ready_exp()));
        end
        if (bus.sym_valid && bus.sym_ready) seen.push_back(bus.sym);
        acc = !rst && bus.in_valid && ready_exp();
        if (rst) q.delete();
        else begin
            if (v && bus.sym_ready) void'(q.pop_front());
            if (acc) push_word(bus.in0, bus.in1, bus.in2, bus.in3);
        end
        @(posedge clk);
        @(negedge clk);
    endtask
    task automatic send(input logic [31:0] w);
        bit a = 0;
        int n = 0;
        {bus.in3, bus.in2, bus.in1, bus.in0} = w;
        bus.in_valid = 1'b1;
        while (!a && n < 200) begin
            cycle(1, a);
            n++;
        end
        if (!a) begin
            $display("FAIL send_timeout: word %h not accepted", w);
            $fatal(1, "stuck");
        end
    endtask
    task automatic wait_until_last();
        bit a;
        int n = 0;
        while (n < 100 && !(q.size() != 0 && q[0][2])) begin
            cycle(1, a);
            n++;
        end
    endtask
    initial begin
        bit a;
        logic [1:0] exp30[16];
        int n;
        exp30 = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd2, 2'd1, 2'd0,
                  2'd0, 2'd0, 2'd0, 2'd0, 2'd3, 2'd3, 2'd3, 2'd3};
        bus.in_valid = 1'b0;
        bus.sym_ready = 1'b1;
        {bus.in3, bus.in2, bus.in1, bus.in0} = 32'hFFFF_FFFF;
        @(negedge clk);
        bus.in_valid = 1'b1;
        cycle(0, a);
        cycle(1, a);
        bus.in_valid = 1'b0;
        rst = 1'b0;
        // single reference word
        seen.delete();
        send(32'hFF00_1BE4);
        bus.in_valid = 1'b0;
        repeat (18) cycle(1, a);
        check("req030_count", 8'(seen.size()), 8'd16);
        for (int i = 0; i < 16 && i < seen.size(); i++) check("req030_sym", 8'(seen[i]), 8'(exp30[i]));
        // three words back to back
        seen.delete();
        send(32'h1234_5678);
        send(32'h9ABC_DEF0);
        send(32'h0F1E_2D3C);
        bus.in_valid = 1'b0;
        repeat (50) cycle(1, a);
        check("req031_count", 8'(seen.size()), 8'd48);
        // random traffic with random backpressure
        repeat (300) begin
            bus.in_valid = 1'($urandom);
            bus.sym_ready = 1'($urandom);
            {bus.in3, bus.in2, bus.in1, bus.in0} = $urandom;
            cycle(1, a);
        end
        bus.in_valid = 1'b0;
        bus.sym_ready = 1'b1;
        repeat (40) cycle(1, a);
        // stall five cycles on the final symbol of a word
        send($urandom);
        bus.in_valid = 1'b0;
        wait_until_last();
        bus.sym_ready = 1'b0;
        repeat (5) cycle(1, a);
        bus.sym_ready = 1'b1;
        repeat (3) cycle(1, a);
        // reset mid-word discards active and pending
        send(32'hA5A5_A5A5);
        send(32'h5A5A_5A5A);
        bus.in_valid = 1'b0;
        n = 0;
        while (n < 100 && q.size() != 25) begin
            cycle(1, a);
            n++;
        end
        rst = 1'b1;
        cycle(1, a);
        rst = 1'b0;
        cycle(1, a);
        send(32'h0000_0003);
        bus.in_valid = 1'b0;
        repeat (20) cycle(1, a);
        // inputs churn while in_ready is low; only the accepted value counts
        bus.sym_ready = 1'b0;
        send($urandom);
        send($urandom);
        repeat (6) begin
            {bus.in3, bus.in2, bus.in1, bus.in0} = $urandom;
            cycle(1, a);
        end
        bus.sym_ready = 1'b1;
        a = 0;
        n = 0;
        while (!a && n < 100) begin
            {bus.in3, bus.in2, bus.in1, bus.in0} = $urandom;
            cycle(1, a);
            n++;
        end
        bus.in_valid = 1'b0;
        repeat (60) begin
            {bus.in3, bus.in2, bus.in1, bus.in0} = $urandom;
            cycle(1, a);
        end
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
